key_event_ctrl: RTL
===================

# key_event_ctrl

Key event controller that sits after the four-key debounce stage and turns the debounced key levels into timed key events for the RTC system's setting logic. It arbitrates between the four keys and tracks one key at a time. It classifies presses as press, long-press, auto-repeat or release, and buffers events in a 4-entry FIFO drained through a valid/ready handshake.

## Interface
- LONG_CYC, 50_000_000, hold time in clock cycles after the PRESS event before LONG fires; legal range 2..2^32-1.
- REPEAT_CYC, 10_000_000, period in cycles between REPEAT events after LONG; legal range 1..2^32-1.
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- key_level  input  4  debounced key levels, synchronous to clk; 0 = pressed, 1 = released.
- evt_valid  output  1  FIFO head holds an event.
- evt_ready  input  1  consumer accepts the head event when evt_valid & evt_ready at a clock edge.
- evt_key  output  2  key index of the head event.
- evt_type  output  2  head event type: 00 PRESS, 01 LONG, 10 REPEAT, 11 RELEASE.
- ovf  output  1  sticky flag: at least one event was dropped because the FIFO was full.
- ovf_clr  input  1  clears ovf on the next edge.

## Operation
- key_prev[3:0] register holds key_level from the previous cycle. A press edge is defined as key_prev[i]=1 & key_level[i]=0.
- FSM states:
  - IDLE: no key tracked. On any press edge, the lowest-index pressed key becomes trk_key, PRESS is enqueued, hold_cnt is cleared to 0, and the FSM goes to HELD. Press edges on other keys in the same cycle are discarded.
  - HELD: hold_cnt increments by 1 per cycle.
    - If key_level[trk_key]=1, enqueue RELEASE and go to IDLE.
    - Else, if hold_cnt = LONG_CYC-1, enqueue LONG, clear hold_cnt and go to RPT.
  - RPT: hold_cnt increments by 1 per cycle.
    - If key_level[trk_key]=1, enqueue RELEASE and go to IDLE.
    - Else, if hold_cnt = REPEAT_CYC-1, enqueue REPEAT and clear hold_cnt.
- Release has priority over LONG/REPEAT on the same edge. The timed event is not generated.
- While in HELD/RPT, all activity on non-tracked keys is ignored. A key still held when tracking returns to IDLE produces no event until it is released and pressed again, because a fresh press edge is required.
- hold_cnt is 32 bits and never wraps: it is cleared at each LONG/REPEAT, so it stays below max(LONG_CYC, REPEAT_CYC).
- FIFO: 4 entries of {key[1:0], type[1:0]}, first-word-fall-through. Pointers are 3 bits (2-bit index plus a wrap bit).
  - full = index bits equal and wrap bits differ.
  - empty = pointers equal.
- Write to a full FIFO with no simultaneous read: the event is dropped and ovf is set.
- Simultaneous read and write when full: the read frees the slot, so the write is accepted and nothing is dropped.
- Simultaneous read and write when empty: no bypass. The event is written, and the read is ignored because evt_valid=0.
- ovf_clr & drop on the same edge: ovf stays 1, because set wins.
- evt_key/evt_type are undefined-but-stable (0) while evt_valid=0.

## Timing
- Reset values: state IDLE, key_prev=4'b1111, hold_cnt=0, FIFO empty, evt_valid=0, evt_key=0, evt_type=0, ovf=0.
- A key held through reset deassertion produces PRESS at the first clock edge after release of rst_n.
- Latency: key_level edge present before edge k, FIFO empty → event written at edge k → evt_valid=1 after edge k (1 cycle).
- PRESS enqueued at edge k → LONG at edge k+LONG_CYC → REPEAT at k+LONG_CYC+m·REPEAT_CYC, m≥1.
- Release seen at edge r → RELEASE written at edge r.
- Handshake: evt_valid stays asserted and the head event stays stable until accepted. Head advances on the edge where evt_valid & evt_ready. Back-to-back acceptance yields one event per cycle.
- rst_n asserted mid-operation: immediate asynchronous clear to the reset values. Queued events are lost.

## Test plan
- LONG_CYC=20, REPEAT_CYC=8, evt_ready=1.
  - Press key 2 at edge 10, release at edge 15 → PRESS(2,00) valid after edge 10, RELEASE(2,11) after edge 15. No LONG.
  - Press key 1 at edge 10, hold to edge 50 → PRESS@10, LONG@30, REPEAT@38, REPEAT@46, RELEASE@50.
- Keys 3 and 0 pressed on the same edge → only PRESS(0). Release 0 while 3 is still held → RELEASE(0), no event for key 3. Release and re-press 3 → PRESS(3).
- Release exactly at edge k+LONG_CYC → RELEASE only, no LONG.
- evt_ready=0, generate 6 events → 4 queued, ovf=1 after the 5th event.
  - Drain → the first four events come out in order.
  - Pulse ovf_clr → ovf=0.
  - With the FIFO full and evt_ready=1, a new event on the same edge → accepted, ovf stays 0.
- Assert rst_n=0 mid-hold with 2 events queued → evt_valid=0 and ovf=0 immediately. With the key still held at reset release → PRESS on the first edge after release.

Source files
------------

// File: rtl/key_event_ctrl.sv
// Key event controller: tracks one debounced key at a time and queues
// PRESS/LONG/REPEAT/RELEASE events in a 4-entry FWFT FIFO.
module key_event_ctrl #(
    parameter logic [31:0] LONG_CYC   = 32'd50_000_000,
    parameter logic [31:0] REPEAT_CYC = 32'd10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_level,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [1:0] evt_key,
    output logic [1:0] evt_type,
    output logic       ovf,
    input  logic       ovf_clr
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HELD,
        ST_RPT
    } state_e;

    localparam logic [1:0] EV_PRESS   = 2'b00;
    localparam logic [1:0] EV_LONG    = 2'b01;
    localparam logic [1:0] EV_REPEAT  = 2'b10;
    localparam logic [1:0] EV_RELEASE = 2'b11;

    state_e      state_q, state_d;
    logic [1:0]  trk_q, trk_d;
    logic [31:0] hold_q, hold_d;
    logic [3:0]  prev_q;
    logic [3:0]  press;

    logic        ev_we;
    logic [1:0]  ev_key;
    logic [1:0]  ev_type;

    logic [3:0]  mem_q [4];
    logic [2:0]  wp_q;
    logic [2:0]  rp_q;
    logic        ovf_q;
    logic        empty;
    logic        full;
    logic        rd;
    logic        wr_ok;
    logic        drop;

    always_comb begin
        press   = prev_q & ~key_level;
        state_d = state_q;
        trk_d   = trk_q;
        hold_d  = hold_q;
        ev_we   = 1'b0;
        ev_key  = trk_q;
        ev_type = EV_PRESS;
        unique case (state_q)
            ST_IDLE: begin
                if (|press) begin
                    // Lowest index wins; simultaneous edges elsewhere are lost.
                    if (press[0])      trk_d = 2'd0;
                    else if (press[1]) trk_d = 2'd1;
                    else if (press[2]) trk_d = 2'd2;
                    else               trk_d = 2'd3;
                    ev_we   = 1'b1;
                    ev_key  = trk_d;
                    ev_type = EV_PRESS;
                    hold_d  = 32'd0;
                    state_d = ST_HELD;
                end
            end
            ST_HELD: begin
                if (key_level[trk_q]) begin
                    ev_we   = 1'b1;
                    ev_type = EV_RELEASE;
                    hold_d  = 32'd0;
                    state_d = ST_IDLE;
                end else if (hold_q == LONG_CYC - 32'd1) begin
                    ev_we   = 1'b1;
                    ev_type = EV_LONG;
                    hold_d  = 32'd0;
                    state_d = ST_RPT;
                end else begin
                    hold_d  = hold_q + 32'd1;
                end
            end
            ST_RPT: begin
                if (key_level[trk_q]) begin
                    ev_we   = 1'b1;
                    ev_type = EV_RELEASE;
                    hold_d  = 32'd0;
                    state_d = ST_IDLE;
                end else if (hold_q == REPEAT_CYC - 32'd1) begin
                    ev_we   = 1'b1;
                    ev_type = EV_REPEAT;
                    hold_d  = 32'd0;
                end else begin
                    hold_d  = hold_q + 32'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                hold_d  = 32'd0;
            end
        endcase
    end

    assign empty = (wp_q == rp_q);
    assign full  = (wp_q[1:0] == rp_q[1:0]) && (wp_q[2] != rp_q[2]);
    assign rd    = !empty && evt_ready;
    // A read on the same edge frees the slot, so a full FIFO still accepts.
    assign wr_ok = ev_we && (!full || rd);
    assign drop  = ev_we && full && !rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            trk_q   <= 2'd0;
            hold_q  <= 32'd0;
            prev_q  <= 4'b1111;
            wp_q    <= 3'd0;
            rp_q    <= 3'd0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= 4'd0;
            end
        end else begin
            state_q <= state_d;
            trk_q   <= trk_d;
            hold_q  <= hold_d;
            prev_q  <= key_level;
            if (wr_ok) begin
                mem_q[wp_q[1:0]] <= {ev_key, ev_type};
                wp_q             <= wp_q + 3'd1;
            end
            if (rd) begin
                rp_q <= rp_q + 3'd1;
            end
            ovf_q <= drop || (ovf_q && !ovf_clr);
        end
    end

    assign evt_valid           = !empty;
    assign {evt_key, evt_type} = empty ? 4'd0 : mem_q[rp_q[1:0]];
    assign ovf                 = ovf_q;

endmodule
